// File: rtl/sdram_req_arb.sv
// sdram_req_arb
//   Two-client request arbiter sitting in front of a single-port SDRAM
//   controller. Port A (CPU) and port B (DMA/video) each present a level
//   request with a write/read flag, a word address, write data and byte
//   enables. One access at a time is forwarded to the controller:
//     - writes are launched by toggling `we` and complete when `we_ack`
//       matches `we`;
//     - reads are launched by a rising edge on `rd` and complete when
//       `rd_rdy` has gone low (accepted) and then high (data valid).
//   The requesting client receives a one-cycle ack and, for reads, the
//   data on its own rdata output (held until that port's next read).
//
// Parameters
//   ROUND_ROBIN   0: A always wins a tie; 1: ties alternate between ports.
//   RETRY_CYCLES  cycles to wait for rd_rdy to drop before re-pulsing rd
//                 (8..255).
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   a_req/a_we/a_addr/
//   a_wdata/a_be            port A request fields (held until a_ack)
//   a_ack, a_rdata          port A completion pulse and read data
//   b_*                     same set for port B
//   raddr, rd, rd_rdy, dout controller read interface
//   waddr, din, be, we,
//   we_ack                  controller write interface
module sdram_req_arb #(
  parameter int ROUND_ROBIN  = 0,
  parameter int RETRY_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [23:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_be,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [23:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [23:0] raddr,
  output logic        rd,
  input  logic        rd_rdy,
  input  logic [15:0] dout,
  output logic [23:0] waddr,
  output logic [15:0] din,
  output logic [1:0]  be,
  output logic        we,
  input  logic        we_ack
);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_ARM,
    RD_WAIT,
    DONE
  } state_t;

  // Last count value before rd is dropped for a re-edge.
  localparam logic [7:0] RETRY_LAST = 8'(RETRY_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        port_reg, port_next;      // port being served: 0 = A, 1 = B
  logic        rr_reg, rr_next;          // preferred port on a tie
  logic [7:0]  retry_reg, retry_next;
  logic        rd_reg, rd_next;
  logic        we_reg, we_next;
  logic [23:0] raddr_reg, raddr_next;
  logic [23:0] waddr_reg, waddr_next;
  logic [15:0] din_reg, din_next;
  logic [1:0]  be_reg, be_next;
  logic        a_ack_reg, a_ack_next;
  logic        b_ack_reg, b_ack_next;
  logic [15:0] a_rdata_reg, a_rdata_next;
  logic [15:0] b_rdata_reg, b_rdata_next;

  // Grant selection and the fields of the winning port.
  logic        grant_b;
  logic        sel_we;
  logic [23:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_be;

  always_comb begin
    grant_b = 1'b0;
    if (b_req && !a_req) begin
      grant_b = 1'b1;
    end else if (b_req && a_req && (ROUND_ROBIN != 0) && rr_reg) begin
      grant_b = 1'b1;
    end
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
    sel_be    = grant_b ? b_be    : a_be;
  end

  always_comb begin
    state_next   = state_reg;
    port_next    = port_reg;
    rr_next      = rr_reg;
    retry_next   = retry_reg;
    rd_next      = rd_reg;
    we_next      = we_reg;
    raddr_next   = raddr_reg;
    waddr_next   = waddr_reg;
    din_next     = din_reg;
    be_next      = be_reg;
    a_ack_next   = 1'b0;
    b_ack_next   = 1'b0;
    a_rdata_next = a_rdata_reg;
    b_rdata_next = b_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (a_req || b_req) begin
          port_next = grant_b;
          if (sel_we) begin
            waddr_next = sel_addr;
            din_next   = sel_wdata;
            be_next    = sel_be;
            we_next    = ~we_reg;
            state_next = WR_WAIT;
          end else begin
            raddr_next = sel_addr;
            rd_next    = 1'b1;
            retry_next = 8'd0;
            state_next = RD_ARM;
          end
        end
      end

      WR_WAIT: begin
        if (we_ack == we_reg) begin
          a_ack_next = ~port_reg;
          b_ack_next = port_reg;
          rr_next    = ~port_reg;
          state_next = DONE;
        end
      end

      RD_ARM: begin
        if (!rd_reg) begin
          // Second half of a re-edge: raise rd again and restart the wait.
          rd_next    = 1'b1;
          retry_next = 8'd0;
        end else if (!rd_rdy) begin
          state_next = RD_WAIT;
        end else if (retry_reg == RETRY_LAST) begin
          // The controller missed the edge; drop rd for one cycle.
          rd_next = 1'b0;
        end else begin
          retry_next = retry_reg + 8'd1;
        end
      end

      RD_WAIT: begin
        if (rd_rdy) begin
          if (port_reg) begin
            b_rdata_next = dout;
            b_ack_next   = 1'b1;
          end else begin
            a_rdata_next = dout;
            a_ack_next   = 1'b1;
          end
          rr_next    = ~port_reg;
          rd_next    = 1'b0;
          state_next = DONE;
        end
      end

      // One dead cycle so the client sees its ack before it can re-request.
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      port_reg    <= 1'b0;
      rr_reg      <= 1'b0;
      retry_reg   <= 8'd0;
      rd_reg      <= 1'b0;
      // Follow the controller's toggle so leaving reset issues no write.
      we_reg      <= we_ack;
      raddr_reg   <= 24'd0;
      waddr_reg   <= 24'd0;
      din_reg     <= 16'd0;
      be_reg      <= 2'd0;
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      a_rdata_reg <= 16'd0;
      b_rdata_reg <= 16'd0;
    end else begin
      state_reg   <= state_next;
      port_reg    <= port_next;
      rr_reg      <= rr_next;
      retry_reg   <= retry_next;
      rd_reg      <= rd_next;
      we_reg      <= we_next;
      raddr_reg   <= raddr_next;
      waddr_reg   <= waddr_next;
      din_reg     <= din_next;
      be_reg      <= be_next;
      a_ack_reg   <= a_ack_next;
      b_ack_reg   <= b_ack_next;
      a_rdata_reg <= a_rdata_next;
      b_rdata_reg <= b_rdata_next;
    end
  end

  assign a_ack   = a_ack_reg;
  assign b_ack   = b_ack_reg;
  assign a_rdata = a_rdata_reg;
  assign b_rdata = b_rdata_reg;
  assign raddr   = raddr_reg;
  assign rd      = rd_reg;
  assign waddr   = waddr_reg;
  assign din     = din_reg;
  assign be      = be_reg;
  assign we      = we_reg;

endmodule

// File: tb/tb_sdram_req_arb.sv
// tb_sdram_req_arb
//   Two arbiter instances: index 0 with ROUND_ROBIN=0, index 1 with
//   ROUND_ROBIN=1, both with RETRY_CYCLES=8. Each has its own behavioural
//   SDRAM controller model (toggle write handshake, rd-edge reads, 256-word
//   memory indexed by address[7:0]). Directed vectors run on instance 0,
//   followed by hand-written sequences for arbitration, missed read edges
//   and resets.
module tb_sdram_req_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        mrst;
  logic [1:0]  reset_n;
  logic [1:0]  a_req, a_we, b_req, b_we;
  logic [23:0] a_addr [2];
  logic [23:0] b_addr [2];
  logic [15:0] a_wdata [2];
  logic [15:0] b_wdata [2];
  logic [1:0]  a_be [2];
  logic [1:0]  b_be [2];
  int          rd_lat [2];
  int          ign_req [2];
  int          kick_req [2];

  wire  [1:0]  a_ack, b_ack, rd, we, rd_rdy_w, we_ack_w;
  wire  [15:0] a_rdata [2];
  wire  [15:0] b_rdata [2];
  wire  [23:0] raddr [2];
  wire  [23:0] waddr [2];
  wire  [15:0] din [2];
  wire  [1:0]  be [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic        rd_rdy_m, we_ack_m, rd_q;
    logic [15:0] dout_m;
    logic [15:0] mem [256];
    logic [7:0]  ra;
    int          rcnt, wcnt, ign_done, kick_done;

    sdram_req_arb #(.ROUND_ROBIN(gi), .RETRY_CYCLES(8)) u_dut (
      .clk(clk), .reset_n(reset_n[gi]),
      .a_req(a_req[gi]), .a_we(a_we[gi]), .a_addr(a_addr[gi]),
      .a_wdata(a_wdata[gi]), .a_be(a_be[gi]), .a_ack(a_ack[gi]), .a_rdata(a_rdata[gi]),
      .b_req(b_req[gi]), .b_we(b_we[gi]), .b_addr(b_addr[gi]),
      .b_wdata(b_wdata[gi]), .b_be(b_be[gi]), .b_ack(b_ack[gi]), .b_rdata(b_rdata[gi]),
      .raddr(raddr[gi]), .rd(rd[gi]), .rd_rdy(rd_rdy_m), .dout(dout_m),
      .waddr(waddr[gi]), .din(din[gi]), .be(be[gi]), .we(we[gi]), .we_ack(we_ack_m)
    );

    assign rd_rdy_w[gi] = rd_rdy_m;
    assign we_ack_w[gi] = we_ack_m;

    // Controller model. It is not reset by the arbiter's reset, only by mrst.
    always @(posedge clk) begin
      if (mrst) begin
        rd_q      <= 1'b0;
        rd_rdy_m  <= 1'b1;
        we_ack_m  <= 1'b0;
        dout_m    <= 16'd0;
        ra        <= 8'd0;
        rcnt      <= 0;
        wcnt      <= 0;
        ign_done  <= 0;
        kick_done <= 0;
      end else begin
        rd_q <= rd[gi];
        if (kick_done != kick_req[gi]) begin
          kick_done <= kick_done + 1;
          we_ack_m  <= ~we_ack_m;
        end else if (reset_n[gi] && (we[gi] != we_ack_m)) begin
          if (wcnt == 2) begin
            if (be[gi][0]) mem[waddr[gi][7:0]][7:0]  <= din[gi][7:0];
            if (be[gi][1]) mem[waddr[gi][7:0]][15:8] <= din[gi][15:8];
            we_ack_m <= we[gi];
            wcnt     <= 0;
          end else begin
            wcnt <= wcnt + 1;
          end
        end
        if (rd[gi] && !rd_q && rcnt == 0) begin
          if (ign_done != ign_req[gi]) begin
            ign_done <= ign_done + 1;
          end else begin
            rd_rdy_m <= 1'b0;
            ra       <= raddr[gi][7:0];
            rcnt     <= rd_lat[gi];
          end
        end else if (rcnt == 1) begin
          dout_m   <= mem[ra];
          rd_rdy_m <= 1'b1;
          rcnt     <= 0;
        end else if (rcnt > 1) begin
          rcnt <= rcnt - 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_port(input int inst, input bit port, input bit req, input bit wr,
                            input logic [23:0] addr, input logic [15:0] wdata,
                            input logic [1:0] bmask);
    if (!port) begin
      a_req[inst] = req; a_we[inst] = wr; a_addr[inst] = addr;
      a_wdata[inst] = wdata; a_be[inst] = bmask;
    end else begin
      b_req[inst] = req; b_we[inst] = wr; b_addr[inst] = addr;
      b_wdata[inst] = wdata; b_be[inst] = bmask;
    end
  endtask

  // Observations from the last run_access call.
  int          obs_acks, obs_other, obs_toggles, obs_rises, obs_match, obs_ackc;
  int          obs_r1, obs_f1, obs_r2;
  logic [23:0] obs_waddr, obs_raddr;
  logic [15:0] obs_din, obs_rdata;
  logic [1:0]  obs_be;
  logic        obs_rd_end;

  task automatic run_access(input string tag, input int inst, input bit port, input bit wr,
                            input logic [23:0] addr, input logic [15:0] wdata,
                            input logic [1:0] bmask);
    logic we_prev, rd_prev, my_ack, oth_ack;
    bit   got;
    obs_acks = 0; obs_other = 0; obs_toggles = 0; obs_rises = 0;
    obs_match = -1; obs_ackc = -1; obs_r1 = -1; obs_f1 = -1; obs_r2 = -1;
    obs_waddr = '0; obs_raddr = '0; obs_din = '0; obs_rdata = '0; obs_be = '0;
    got = 1'b0;
    @(negedge clk);
    we_prev = we[inst];
    rd_prev = rd[inst];
    drive_port(inst, port, 1'b1, wr, addr, wdata, bmask);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      my_ack  = port ? b_ack[inst] : a_ack[inst];
      oth_ack = port ? a_ack[inst] : b_ack[inst];
      if (oth_ack) obs_other++;
      if (we[inst] != we_prev) begin
        obs_toggles++;
        obs_waddr = waddr[inst]; obs_din = din[inst]; obs_be = be[inst];
      end
      if (rd[inst] && !rd_prev) begin
        obs_rises++;
        obs_raddr = raddr[inst];
        if (obs_r1 < 0) obs_r1 = c;
        else if (obs_r2 < 0) obs_r2 = c;
      end
      if (!rd[inst] && rd_prev && obs_f1 < 0) obs_f1 = c;
      if (wr && obs_toggles > 0 && obs_match < 0 && we_ack_w[inst] == we[inst]) obs_match = c;
      we_prev = we[inst];
      rd_prev = rd[inst];
      if (my_ack) begin
        obs_acks++;
        if (!got) begin
          got = 1'b1;
          obs_ackc  = c;
          obs_rdata = port ? b_rdata[inst] : a_rdata[inst];
          drive_port(inst, port, 1'b0, wr, addr, wdata, bmask);
        end
      end
      if (got && c >= obs_ackc + 4) break;
    end
    obs_rd_end = rd[inst];
    check({tag, ".ack_seen"}, 32'(got), 32'd1);
    $display("txn %s inst=%0d port=%s %s addr=%06h wdata=%04h be=%b ack_cycle=%0d rdata=%04h",
             tag, inst, port ? "B" : "A", wr ? "WR" : "RD", addr, wdata, bmask, obs_ackc, obs_rdata);
  endtask

  // Both ports request writes continuously; record the order of the first 4 acks.
  task automatic run_both(input string tag, input int inst, input logic [3:0] exp_ord);
    logic [3:0] ord;
    int n, both, extra;
    ord = 4'd0; n = 0; both = 0; extra = 0;
    @(negedge clk);
    drive_port(inst, 1'b0, 1'b1, 1'b1, 24'h000100, 16'h1111, 2'b11);
    drive_port(inst, 1'b1, 1'b1, 1'b1, 24'h000200, 16'h2222, 2'b11);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a_ack[inst] && b_ack[inst]) both++;
      if ((a_ack[inst] || b_ack[inst]) && n < 4) begin
        ord[n] = b_ack[inst];
        n++;
      end
      if (n == 4) break;
    end
    drive_port(inst, 1'b0, 1'b0, 1'b1, 24'h000100, 16'h1111, 2'b11);
    drive_port(inst, 1'b1, 1'b0, 1'b1, 24'h000200, 16'h2222, 2'b11);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_ack[inst] || b_ack[inst]) extra++;
    end
    check({tag, ".count"}, 32'(n), 32'd4);
    check({tag, ".order"}, 32'(ord), 32'(exp_ord));
    check({tag, ".both_ack"}, 32'(both), 32'd0);
    check({tag, ".extra_ack"}, 32'(extra), 32'd0);
    $display("txn %s inst=%0d grants(bit i: 1=B)=%b", tag, inst, ord);
  endtask

  typedef struct {
    bit          port;
    bit          wr;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [1:0]  bmask;
    logic [15:0] exp_rdata;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt, acks, rdhi;
    bit  ok;
    logic we_prev;

    vec[0] = '{1'b0, 1'b1, 24'h000123, 16'hBEEF, 2'b11, 16'h0000};
    vec[1] = '{1'b0, 1'b1, 24'h000010, 16'h5A5A, 2'b11, 16'h0000};
    vec[2] = '{1'b1, 1'b0, 24'h000010, 16'h0000, 2'b00, 16'h5A5A};
    vec[3] = '{1'b0, 1'b1, 24'h000020, 16'h1234, 2'b11, 16'h0000};
    vec[4] = '{1'b0, 1'b1, 24'h000020, 16'hABCD, 2'b01, 16'h0000};
    vec[5] = '{1'b1, 1'b0, 24'h000020, 16'h0000, 2'b00, 16'h12CD};
    vec[6] = '{1'b0, 1'b1, 24'h000020, 16'h5678, 2'b10, 16'h0000};
    vec[7] = '{1'b0, 1'b0, 24'h000020, 16'h0000, 2'b00, 16'h56CD};
    vec[8] = '{1'b1, 1'b1, 24'hABCD40, 16'hC0DE, 2'b11, 16'h0000};
    vec[9] = '{1'b0, 1'b0, 24'hABCD40, 16'h0000, 2'b00, 16'hC0DE};

    mrst = 1'b1;
    reset_n = 2'b00;
    a_req = 2'b00; a_we = 2'b00; b_req = 2'b00; b_we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a_addr[i] = '0; b_addr[i] = '0; a_wdata[i] = '0; b_wdata[i] = '0;
      a_be[i] = '0; b_be[i] = '0; rd_lat[i] = 3; ign_req[i] = 0; kick_req[i] = 0;
    end
    repeat (3) @(negedge clk);
    mrst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d.rd", i), 32'(rd[i]), 32'd0);
      check($sformatf("rst%0d.a_ack", i), 32'(a_ack[i]), 32'd0);
      check($sformatf("rst%0d.b_ack", i), 32'(b_ack[i]), 32'd0);
      check($sformatf("rst%0d.a_rdata", i), 32'(a_rdata[i]), 32'd0);
      check($sformatf("rst%0d.b_rdata", i), 32'(b_rdata[i]), 32'd0);
      check($sformatf("rst%0d.raddr", i), 32'(raddr[i]), 32'd0);
      check($sformatf("rst%0d.waddr", i), 32'(waddr[i]), 32'd0);
      check($sformatf("rst%0d.din", i), 32'(din[i]), 32'd0);
      check($sformatf("rst%0d.be", i), 32'(be[i]), 32'd0);
      check($sformatf("rst%0d.we", i), 32'(we[i]), 32'd0);
    end
    reset_n = 2'b11;
    repeat (2) @(negedge clk);

    // Directed vectors on instance 0.
    for (int i = 0; i < NV; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      run_access(t, 0, vec[i].port, vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].bmask);
      check({t, ".acks"}, 32'(obs_acks), 32'd1);
      check({t, ".other_ack"}, 32'(obs_other), 32'd0);
      check({t, ".rd_end"}, 32'(obs_rd_end), 32'd0);
      if (vec[i].wr) begin
        check({t, ".we_toggles"}, 32'(obs_toggles), 32'd1);
        check({t, ".rd_rises"}, 32'(obs_rises), 32'd0);
        check({t, ".waddr"}, 32'(obs_waddr), 32'(vec[i].addr));
        check({t, ".din"}, 32'(obs_din), 32'(vec[i].wdata));
        check({t, ".be"}, 32'(obs_be), 32'(vec[i].bmask));
        check({t, ".ack_latency"}, 32'(obs_ackc - obs_match), 32'd1);
      end else begin
        check({t, ".we_toggles"}, 32'(obs_toggles), 32'd0);
        check({t, ".rd_rises"}, 32'(obs_rises), 32'd1);
        check({t, ".raddr"}, 32'(obs_raddr), 32'(vec[i].addr));
        check({t, ".rdata"}, 32'(obs_rdata), 32'(vec[i].exp_rdata));
      end
    end

    // Missed read: controller ignores the first rd edge.
    ign_req[0] = ign_req[0] + 1;
    run_access("miss", 0, 1'b0, 1'b0, 24'h000123, 16'h0000, 2'b00);
    check("miss.acks", 32'(obs_acks), 32'd1);
    check("miss.rd_rises", 32'(obs_rises), 32'd2);
    check("miss.high_cycles", 32'(obs_f1 - obs_r1), 32'd8);
    check("miss.low_cycles", 32'(obs_r2 - obs_f1), 32'd1);
    check("miss.rdata", 32'(obs_rdata), 32'hBEEF);
    check("miss.rd_end", 32'(obs_rd_end), 32'd0);

    // Arbitration with both ports held.
    run_both("prio", 0, 4'b0000);
    run_both("rr", 1, 4'b1010);

    // Reset while the controller holds we_ack flipped to 1.
    @(negedge clk);
    reset_n[0] = 1'b0;
    kick_req[0] = kick_req[0] + 1;
    repeat (3) @(negedge clk);
    reset_n[0] = 1'b1;
    cnt = 0; acks = 0;
    we_prev = we[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (we[0] != we_prev) cnt++;
      if (a_ack[0] || b_ack[0]) acks++;
      we_prev = we[0];
    end
    check("rstwe.we_eq_ack", 32'(we[0]), 32'(we_ack_w[0]));
    check("rstwe.we", 32'(we[0]), 32'd1);
    check("rstwe.toggles", 32'(cnt), 32'd0);
    check("rstwe.acks", 32'(acks), 32'd0);
    $display("txn rstwe we=%b we_ack=%b", we[0], we_ack_w[0]);

    // Reset while waiting for read data.
    rd_lat[0] = 20;
    @(negedge clk);
    drive_port(0, 1'b0, 1'b1, 1'b0, 24'h000010, 16'h0000, 2'b00);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!rd_rdy_w[0]) begin ok = 1'b1; break; end
    end
    check("rstrd.accepted", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    reset_n[0] = 1'b0;
    drive_port(0, 1'b0, 1'b0, 1'b0, 24'h000010, 16'h0000, 2'b00);
    repeat (2) @(negedge clk);
    check("rstrd.rd_in_reset", 32'(rd[0]), 32'd0);
    reset_n[0] = 1'b1;
    acks = 0; rdhi = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_ack[0] || b_ack[0]) acks++;
      if (rd[0]) rdhi++;
    end
    check("rstrd.acks", 32'(acks), 32'd0);
    check("rstrd.rd_high", 32'(rdhi), 32'd0);
    check("rstrd.a_rdata", 32'(a_rdata[0]), 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (rd_rdy_w[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rstrd.ctrl_idle", 32'(ok), 32'd1);
    $display("txn rstrd abandoned read, acks=%0d rd_high=%0d", acks, rdhi);
    rd_lat[0] = 3;
    run_access("post", 0, 1'b0, 1'b0, 24'h000010, 16'h0000, 2'b00);
    check("post.acks", 32'(obs_acks), 32'd1);
    check("post.rd_rises", 32'(obs_rises), 32'd1);
    check("post.rdata", 32'(obs_rdata), 32'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
